// File: rtl/call_stack_ras_if.sv
// Decoder/fetch-side bundle for the return-address stack.
// master = jump decoder + redirect logic, slave = the stack itself.
interface call_stack_ras_if #(
  parameter int unsigned PTR_W    = 4,
  parameter int unsigned IP_WIDTH = 48
);
  localparam int unsigned CkptW = 2 * PTR_W + 1;

  logic                push_en;
  logic [IP_WIDTH-1:0] push_addr;
  logic                pop_en;
  logic                restore_en;
  logic [CkptW-1:0]    restore_ckpt;
  logic [CkptW-1:0]    ckpt_out;
  logic                pred_valid;
  logic [IP_WIDTH-1:0] pred_addr;
  logic                underflow;
  logic [7:0]          ovf_cnt;

  modport master (
    output push_en, push_addr, pop_en, restore_en, restore_ckpt,
    input  ckpt_out, pred_valid, pred_addr, underflow, ovf_cnt
  );

  modport slave (
    input  push_en, push_addr, pop_en, restore_en, restore_ckpt,
    output ckpt_out, pred_valid, pred_addr, underflow, ovf_cnt
  );
endinterface

// File: rtl/call_stack_ras.sv
// Return-address stack: pushes fall-through IPs on calls, predicts ret targets one cycle
// after a pop, and restores exactly from a {count,tos} checkpoint on mispredict/flush.
module call_stack_ras #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PTR_W    = 4,
  parameter int unsigned IP_WIDTH = 48
) (
  input logic             clk,
  input logic             rst,
  call_stack_ras_if.slave bus
);

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [PTR_W:0]      cnt_t;
  typedef logic [IP_WIDTH-1:0] addr_t;

  localparam ptr_t PtrOne  = ptr_t'(1);
  localparam ptr_t TosRst  = ptr_t'(DEPTH - 1);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam cnt_t CntFull = cnt_t'(DEPTH);

  // Entry array is deliberately not reset; contents are don't-care while empty.
  addr_t mem_q [DEPTH];

  ptr_t       tos_q, tos_d;
  cnt_t       cnt_q, cnt_d;
  logic       pred_valid_q, pred_valid_d;
  addr_t      pred_addr_q, pred_addr_d;
  logic       underflow_q, underflow_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  logic  mem_we;
  ptr_t  mem_waddr;
  addr_t top_rdata;
  ptr_t  tos_inc, tos_dec;
  cnt_t  ckpt_cnt;
  ptr_t  ckpt_tos;
  logic  empty, full;

  assign tos_inc   = tos_q + PtrOne;
  assign tos_dec   = tos_q - PtrOne;
  assign top_rdata = mem_q[tos_q];
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q >= CntFull);
  assign {ckpt_cnt, ckpt_tos} = bus.restore_ckpt;

  always_comb begin
    tos_d        = tos_q;
    cnt_d        = cnt_q;
    pred_valid_d = 1'b0;
    pred_addr_d  = pred_addr_q;
    underflow_d  = 1'b0;
    ovf_cnt_d    = ovf_cnt_q;
    mem_we       = 1'b0;
    mem_waddr    = tos_inc;

    if (bus.restore_en) begin
      // A corrupted checkpoint must never claim more entries than exist.
      cnt_d = (ckpt_cnt > CntFull) ? CntFull : ckpt_cnt;
      tos_d = ckpt_tos;
    end else if (bus.pop_en) begin
      if (!empty) begin
        pred_addr_d  = top_rdata;
        pred_valid_d = 1'b1;
        if (bus.push_en) begin
          // ret+call bundle: the popped slot is immediately refilled.
          mem_we    = 1'b1;
          mem_waddr = tos_q;
        end else begin
          tos_d = tos_dec;
          cnt_d = cnt_q - CntOne;
        end
      end else begin
        underflow_d = 1'b1;
        if (bus.push_en) begin
          mem_we    = 1'b1;
          mem_waddr = tos_inc;
          tos_d     = tos_inc;
          cnt_d     = CntOne;
        end
      end
    end else if (bus.push_en) begin
      mem_we    = 1'b1;
      mem_waddr = tos_inc;
      tos_d     = tos_inc;
      if (!full) begin
        cnt_d = cnt_q + CntOne;
      end else if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tos_q        <= TosRst;
      cnt_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_addr_q  <= '0;
      underflow_q  <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      tos_q        <= tos_d;
      cnt_q        <= cnt_d;
      pred_valid_q <= pred_valid_d;
      pred_addr_q  <= pred_addr_d;
      underflow_q  <= underflow_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= bus.push_addr;
    end
  end

  assign bus.ckpt_out   = {cnt_q, tos_q};
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_addr  = pred_addr_q;
  assign bus.underflow  = underflow_q;
  assign bus.ovf_cnt    = ovf_cnt_q;

  cnt_bounded_a: assert property (@(posedge clk) disable iff (!rst) cnt_q <= CntFull);
  pred_xor_uf_a: assert property (@(posedge clk) disable iff (!rst)
                                  !(pred_valid_q && underflow_q));

endmodule

// File: tb/tb_call_stack_ras.sv
// Randomized and directed bench for call_stack_ras against an in-bench stack model.
module tb_call_stack_ras;
  localparam int DEPTH    = 16;
  localparam int PTR_W    = 4;
  localparam int IP_WIDTH = 48;
  localparam int CKPT_W   = 2 * PTR_W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  call_stack_ras_if #(.PTR_W(PTR_W), .IP_WIDTH(IP_WIDTH)) bus ();

  call_stack_ras #(
    .DEPTH   (DEPTH),
    .PTR_W   (PTR_W),
    .IP_WIDTH(IP_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference stack: plain ints for pointer/count, array for entries.
  logic [IP_WIDTH-1:0] m_mem [DEPTH];
  int                  m_tos, m_cnt, m_ovf;
  bit                  m_pv, m_uf;
  logic [IP_WIDTH-1:0] m_pa;

  function automatic logic [CKPT_W-1:0] m_ckpt();
    return CKPT_W'(m_cnt * DEPTH + m_tos);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tos = DEPTH - 1;
      m_cnt = 0;
      m_ovf = 0;
      m_pv  = 1'b0;
      m_uf  = 1'b0;
      m_pa  = '0;
    end else if (bus.restore_en) begin
      m_cnt = int'(bus.restore_ckpt) / DEPTH;
      if (m_cnt > DEPTH) m_cnt = DEPTH;
      m_tos = int'(bus.restore_ckpt) % DEPTH;
      m_pv  = 1'b0;
      m_uf  = 1'b0;
    end else if (bus.pop_en) begin
      if (m_cnt > 0) begin
        m_pa = m_mem[m_tos];
        m_pv = 1'b1;
        m_uf = 1'b0;
        if (bus.push_en) begin
          m_mem[m_tos] = bus.push_addr;
        end else begin
          m_tos = (m_tos + DEPTH - 1) % DEPTH;
          m_cnt = m_cnt - 1;
        end
      end else begin
        m_pv = 1'b0;
        m_uf = 1'b1;
        if (bus.push_en) begin
          m_tos = (m_tos + 1) % DEPTH;
          m_mem[m_tos] = bus.push_addr;
          m_cnt = 1;
        end
      end
    end else if (bus.push_en) begin
      m_tos = (m_tos + 1) % DEPTH;
      m_mem[m_tos] = bus.push_addr;
      if (m_cnt < DEPTH) m_cnt = m_cnt + 1;
      else if (m_ovf < 255) m_ovf = m_ovf + 1;
      m_pv = 1'b0;
      m_uf = 1'b0;
    end else begin
      m_pv = 1'b0;
      m_uf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("ckpt_out", 64'(bus.ckpt_out), 64'(m_ckpt()));
      check("pred_valid", 64'(bus.pred_valid), 64'(m_pv));
      check("pred_addr", 64'(bus.pred_addr), 64'(m_pa));
      check("underflow", 64'(bus.underflow), 64'(m_uf));
      check("ovf_cnt", 64'(bus.ovf_cnt), 64'(m_ovf));
    end
  end

  task automatic idle_inputs();
    bus.push_en      = 1'b0;
    bus.push_addr    = '0;
    bus.pop_en       = 1'b0;
    bus.restore_en   = 1'b0;
    bus.restore_ckpt = '0;
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge.
  task automatic cyc(input bit push, input logic [IP_WIDTH-1:0] addr, input bit pop,
                     input bit rest, input logic [CKPT_W-1:0] ck);
    bus.push_en      = push;
    bus.push_addr    = addr;
    bus.pop_en       = pop;
    bus.restore_en   = rest;
    bus.restore_ckpt = ck;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [CKPT_W-1:0] saved [8];

  initial begin
    idle_inputs();
    #1 rst = 1'b0;
    #1 chk_on = 1'b1;
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic LIFO order.
    check("rst_ckpt", 64'(bus.ckpt_out), 64'h00F);
    cyc(1, 48'h1000, 0, 0, '0);
    cyc(1, 48'h2000, 0, 0, '0);
    cyc(1, 48'h3000, 0, 0, '0);
    check("push3_ckpt", 64'(bus.ckpt_out), 64'h032);
    cyc(0, '0, 1, 0, '0);
    check("pop1_addr", 64'(bus.pred_addr), 64'h3000);
    check("pop1_valid", 64'(bus.pred_valid), 64'h1);
    cyc(0, '0, 1, 0, '0);
    check("pop2_addr", 64'(bus.pred_addr), 64'h2000);
    cyc(0, '0, 1, 0, '0);
    check("pop3_addr", 64'(bus.pred_addr), 64'h1000);
    check("pop3_ckpt", 64'(bus.ckpt_out), 64'h00F);

    // Pop from empty.
    cyc(0, '0, 1, 0, '0);
    check("uf_pulse", 64'(bus.underflow), 64'h1);
    check("uf_pv", 64'(bus.pred_valid), 64'h0);
    check("uf_ckpt", 64'(bus.ckpt_out), 64'h00F);
    cyc(0, '0, 0, 0, '0);
    check("uf_clear", 64'(bus.underflow), 64'h0);

    // Overwrite-oldest on the 17th push.
    for (int i = 0; i <= 16; i++) cyc(1, 48'hA000 + 48'(i), 0, 0, '0);
    check("full_ckpt", 64'(bus.ckpt_out), 64'h100);
    check("ovf_one", 64'(bus.ovf_cnt), 64'h1);
    for (int i = 16; i >= 1; i--) begin
      cyc(0, '0, 1, 0, '0);
      check("wrap_pop", 64'(bus.pred_addr), 64'hA000 + 64'(i));
    end
    cyc(0, '0, 1, 0, '0);
    check("wrap_uf", 64'(bus.underflow), 64'h1);

    // Asynchronous reset between clock edges.
    cyc(1, 48'h111, 0, 0, '0);
    cyc(1, 48'h222, 0, 0, '0);
    cyc(1, 48'h333, 0, 0, '0);
    #2 rst = 1'b0;
    #1;
    check("arst_ckpt", 64'(bus.ckpt_out), 64'h00F);
    check("arst_pv", 64'(bus.pred_valid), 64'h0);
    check("arst_ovf", 64'(bus.ovf_cnt), 64'h0);
    #3 rst = 1'b1;
    cyc(0, '0, 1, 0, '0);
    check("arst_uf", 64'(bus.underflow), 64'h1);

    // Restore beats a simultaneous pop.
    do_reset();
    cyc(1, 48'hA, 0, 0, '0);
    check("ck_capture", 64'(bus.ckpt_out), 64'h010);
    cyc(1, 48'hB, 0, 0, '0);
    cyc(0, '0, 1, 0, '0);
    check("ck_popB", 64'(bus.pred_addr), 64'hB);
    cyc(0, '0, 1, 1, 9'h010);
    check("ck_restored", 64'(bus.ckpt_out), 64'h010);
    check("ck_pv", 64'(bus.pred_valid), 64'h0);
    cyc(0, '0, 1, 0, '0);
    check("ck_popA", 64'(bus.pred_addr), 64'hA);

    // Push+pop bundle.
    do_reset();
    cyc(1, 48'h10, 0, 0, '0);
    cyc(1, 48'h20, 0, 0, '0);
    cyc(1, 48'h30, 1, 0, '0);
    check("pp_addr", 64'(bus.pred_addr), 64'h20);
    check("pp_ckpt", 64'(bus.ckpt_out), 64'h021);
    cyc(0, '0, 1, 0, '0);
    check("pp_pop1", 64'(bus.pred_addr), 64'h30);
    cyc(0, '0, 1, 0, '0);
    check("pp_pop2", 64'(bus.pred_addr), 64'h10);

    // Restore count clamp and ovf saturation.
    cyc(0, '0, 0, 1, 9'h1F3);
    check("clamp_ckpt", 64'(bus.ckpt_out), 64'h103);
    do_reset();
    for (int i = 0; i < 300; i++) cyc(1, 48'(i), 0, 0, '0);
    check("ovf_sat", 64'(bus.ovf_cnt), 64'hFF);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 8; i++) saved[i] = 9'h00F;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [IP_WIDTH-1:0] a;
      r = int'($urandom_range(0, 99));
      a = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) saved[$urandom_range(0, 7)] = m_ckpt();
      if (r < 35)      cyc(1, a, 0, 0, '0);
      else if (r < 65) cyc(0, '0, 1, 0, '0);
      else if (r < 78) cyc(1, a, 1, 0, '0);
      else if (r < 87) cyc(r[0], a, r[1], 1, saved[$urandom_range(0, 7)]);
      else if (r < 89) cyc(0, '0, 1, 1, 9'($urandom));
      else if (r < 90 && $urandom_range(0, 9) == 0) do_reset();
      else             cyc(0, '0, 0, 0, '0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_stack_ras.md
Name: call_stack_ras

Overview:
- Return-address stack fed directly by the jump decoder's pushCallStack/popCallStack outputs.
- On a call it pushes the fall-through IP; on a ret it supplies the predicted target one cycle later to the fetch redirect logic.
- It exports a {count,tos} checkpoint with every jump so a mispredict or flush restores the stack exactly, not a drained copy.

Parameters:
- DEPTH, 16, number of stack entries; power of two, at least 4.
- PTR_W, 4, log2(DEPTH).
- IP_WIDTH, 48, return address width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset; 0 = reset asserted.
- push_en  input  1  call decoded this cycle (pushCallStack qualified by instruction valid).
- push_addr  input  IP_WIDTH  return address, i.e. fall-through IP of the call.
- pop_en  input  1  ret decoded this cycle (popCallStack qualified by instruction valid).
- restore_en  input  1  mispredict/flush restore request.
- restore_ckpt  input  PTR_W+PTR_W+1  {count,tos} captured with the offending jump.
- ckpt_out  output  PTR_W+PTR_W+1  current {count,tos} before this cycle's push/pop; travels with the jump.
- pred_valid  output  1  registered; pred_addr holds a valid ret target.
- pred_addr  output  IP_WIDTH  registered predicted return target.
- underflow  output  1  registered one-cycle pulse: pop attempted while count==0.
- ovf_cnt  output  8  saturating count of overwrite-oldest pushes.

Behaviour:

State and reset:
- State is an entry array[DEPTH] of IP_WIDTH, tos[PTR_W] (index of top entry) and count[PTR_W:0].
- On rst low, asynchronously: tos=DEPTH-1, count=0, pred_valid=0, pred_addr=0, underflow=0, ovf_cnt=0.
- The entry array is not reset; its contents are don't-care while count==0.
- ckpt_out is combinational {count,tos}. It is 0 count and tos=DEPTH-1 during reset.

Per-cycle priority:
1. restore_en:
   - Load {count,tos} from restore_ckpt.
   - Ignore push_en and pop_en in that cycle.
   - Next cycle: pred_valid=0, underflow=0.
   - Entries are not rewritten; entries overwritten after the checkpoint stay corrupted. This is an accepted prediction inaccuracy, not an error.
   - A restore_ckpt count greater than DEPTH is clamped to DEPTH.
2. pop_en only:
   - If count>0: pred_addr<=array[tos], pred_valid<=1, tos<=tos-1 (mod DEPTH), count<=count-1.
   - If count==0: pred_valid<=0, underflow<=1, tos and count unchanged.
3. push_en only:
   - tos<=tos+1 (mod DEPTH), array[tos+1]<=push_addr.
   - count<=count+1 if count<DEPTH.
   - Otherwise count stays DEPTH (oldest overwritten by wrap) and ovf_cnt<=ovf_cnt+1, saturating at 255.
   - pred_valid<=0.
4. push_en and pop_en together (ret then call in one bundle):
   - Pop semantics first: pred_addr<=array[tos] if count>0, else pred_valid=0 and underflow=1.
   - Then write push_addr into the slot now at top.
   - count>0: array[tos]<=push_addr; tos and count unchanged.
   - count==0: tos<=tos+1, array[tos+1]<=push_addr, count<=1.
5. Neither: pred_valid<=0, underflow<=0. pred_addr holds its last value.

Timing and handshakes:
- pred_addr/pred_valid are valid exactly one cycle after pop_en.
- No backpressure; the producer holds off push_en/pop_en when stalled.
- A read of array[tos] in the same cycle as a push to the same index returns the pre-write value. It is a registered read of old data; no bypass is required because of the priority above.
- rst asserted mid-operation clears state immediately, independent of clk.

Test Plan:
- Reset, then push 0x1000, 0x2000, 0x3000, then pop ×3 -> pred_addr 0x3000, 0x2000, 0x1000 on the cycles after each pop, pred_valid=1 each; ckpt_out count returns to 0.
- Pop from empty -> next cycle pred_valid=0, underflow=1 for exactly one cycle; tos stays 15, count stays 0.
- Push 17 distinct addresses A0..A16 (DEPTH=16) -> count=16, ovf_cnt=1; 16 pops return A16..A1 and the 17th pop underflows.
- Push 0xA, capture ckpt_out (count=1, tos=0), push 0xB, pop, restore_en with captured ckpt asserted together with pop_en -> pop ignored, count=1, tos=0; next pop returns 0xA.
- Count=2 (0x10, 0x20), then push_en+pop_en with push_addr=0x30 -> pred_addr=0x20, count stays 2; the next two pops return 0x30, 0x10.
- Assert rst low asynchronously between clock edges after 3 pushes -> count=0, pred_valid=0, ovf_cnt=0 immediately; the first pop after release underflows.
